// File: rtl/mul_feed_769.sv
// Shift-add modular-multiply front end for the mod-769 Barrett reducer: a*b folded to 19 bits.
// Optional operand range reduction and err_range pulse under MUL_FEED_769_RANGE_CHECK_EN.
module mul_feed_769 #(
  parameter int Q     = 769,
  parameter int W_IN  = 10,
  parameter int W_OUT = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] dout,
  output logic             busy,
  output logic             err_range
);

  localparam int ACC_W = 2 * W_IN;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FOLD = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  // Largest multiple of Q below 2^19; subtracting it pulls any 20-bit product under 2^19.
  localparam logic [ACC_W-1:0] FOLD_K = ACC_W'(Q * 681);
  localparam logic [3:0] CNT_LAST = 4'(W_IN - 1);

  logic [1:0]       state_q, state_d;
  logic [W_IN-1:0]  ra_q, ra_d, rb_q, rb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [W_OUT-1:0] dout_q, dout_d;

  function automatic logic [W_OUT-1:0] fold(input logic [ACC_W-1:0] x);
    return x[ACC_W-1] ? W_OUT'(x - FOLD_K) : x[W_OUT-1:0];
  endfunction

`ifdef MUL_FEED_769_RANGE_CHECK_EN
  logic err_q, err_d;

  function automatic logic [W_IN-1:0] range_fix(input logic [W_IN-1:0] op);
    return (op >= W_IN'(Q)) ? op - W_IN'(Q) : op;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
`ifdef MUL_FEED_769_RANGE_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef MUL_FEED_769_RANGE_CHECK_EN
          ra_d  = range_fix(a);
          rb_d  = range_fix(b);
          err_d = (a >= W_IN'(Q)) || (b >= W_IN'(Q));
`else
          ra_d  = a;
          rb_d  = b;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (rb_q[cnt_q]) acc_d = acc_q + (ACC_W'(ra_q) << cnt_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_FOLD;
      end
      S_FOLD: begin
        dout_d  = fold(acc_q);
        state_d = S_HOLD;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Operand and accumulator registers are always reloaded at capture, so they need no reset.
  always_ff @(posedge clk) begin
    ra_q  <= ra_d;
    rb_q  <= rb_d;
    acc_q <= acc_d;
  end

`ifdef MUL_FEED_769_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign dout      = dout_q;

endmodule

// File: tb/tb_mul_feed_769.sv
// Scoreboard bench for mul_feed_769: directed operand pairs, back-pressure and mid-operation reset.
module tb_mul_feed_769;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] dout;
  logic        busy;
  logic        err_range;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [18:0] exp_q[$];

  mul_feed_769 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one pop per transfer cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_range === 1'b1) err_pulses++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", dout);
      end else begin
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the acceptance edge.
  task automatic issue(input logic [9:0] av, input logic [9:0] bv,
                       input logic [18:0] e, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k, output bit rdy_seen);
    k = 0; rdy_seen = 0;
    while (!out_valid && k < 50) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 32'(out_valid), 32'd0);
  endtask

  logic [18:0] e_1023_1, e_1023_1023;
  int exp_pulses;

  initial begin
    int k;
    bit rdy_seen;
    logic [18:0] held;
`ifdef MUL_FEED_769_RANGE_CHECK_EN
    e_1023_1 = 19'd254; e_1023_1023 = 19'd64516; exp_pulses = 3;
`else
    e_1023_1 = 19'd1023; e_1023_1023 = 19'd522840; exp_pulses = 0;
`endif
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_err", 32'(err_range), 32'd0);

    // 5*7 with latency measurement
    issue(10'd5, 10'd7, 19'd35, 1);
    check("busy_in_mul", 32'(busy), 32'd1);
    wait_valid(k, rdy_seen);
    check("latency", 32'(k), 32'd11);
    check("in_ready_low_while_busy", 32'(rdy_seen), 32'd0);
    drain();
    check("in_ready_after_xfer", 32'(in_ready), 32'd1);

    issue(10'd768, 10'd768, 19'd66135, 1);   wait_valid(k, rdy_seen); drain();
    issue(10'd0, 10'd1023, 19'd0, 1);        wait_valid(k, rdy_seen); drain();
    issue(10'd1023, 10'd1, e_1023_1, 1);     wait_valid(k, rdy_seen); drain();
    issue(10'd1023, 10'd1023, e_1023_1023, 1); wait_valid(k, rdy_seen); drain();
    issue(10'd600, 10'd300, 19'd180000, 1);  wait_valid(k, rdy_seen); drain();

    // Back-pressure: 12*13 held for 5 cycles while a second request is offered.
    out_ready = 1'b0;
    issue(10'd12, 10'd13, 19'd156, 1);
    wait_valid(k, rdy_seen);
    held = dout;
    check("bp_dout_value", 32'(held), 32'd156);
    a = 10'd100; b = 10'd100; in_valid = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dout !== held || !out_valid) rdy_seen = 1;
      if (in_ready) rdy_seen = 1;
    end
    check("bp_stable", 32'(rdy_seen), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_xfer_out_valid", 32'(out_valid), 32'd0);
    check("bp_xfer_in_ready", 32'(in_ready), 32'd1);
    check("bp_xfer_busy", 32'(busy), 32'd0);

    // Reset in the middle of multiplying 9*9, then 3*3 must be clean.
    issue(10'd9, 10'd9, 19'd0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    issue(10'd3, 10'd3, 19'd9, 1); wait_valid(k, rdy_seen);
    check("post_rst_latency", 32'(k), 32'd11);
    drain();

    repeat (3) @(posedge clk); #1;
    check("err_pulses", 32'(err_pulses), 32'(exp_pulses));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_feed_769.md
# mul_feed_769

Sequential modular-multiply front end that sits directly upstream of the mod-769 Barrett reducer. It accepts two residue operands over a valid/ready handshake and forms their product with an iterative shift-add multiplier. It folds the 20-bit product into a 19-bit value congruent mod 769 and presents it on a valid/ready output that drives the reducer's `din_a`. The reducer's 10-bit `dout_r` is therefore `(a*b) mod 769`.

## Interface
Parameters:
- `Q`, 769, modulus. Fixed; only 769 is verified.
- `W_IN`, 10, operand width.
- `W_OUT`, 19, output width; matches reducer `din_a`.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  10  operand A.
- `b`  input  10  operand B.
- `out_valid`  output  1  `dout` valid.
- `out_ready`  input  1  downstream accepts `dout`.
- `dout`  output  19  folded product, feeds reducer `din_a`.
- `busy`  output  1  high in any state other than IDLE.
- `err_range`  output  1  one-cycle pulse when an out-of-range operand is captured (macro only; tied 0 otherwise).

## Operation
- FSM states: IDLE, MUL, FOLD, HOLD.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `a` into `ra`, `b` into `rb`, clear the 20-bit accumulator `acc`, set `cnt`=0, go to MUL.
- MUL, one bit of `rb` per cycle, LSB first:
  - If `rb[cnt]`, then `acc <= acc + (ra << cnt)`.
  - `cnt` increments each cycle.
  - After `cnt`=9 is processed, go to FOLD.
- FOLD, single cycle:
  - If `acc[19]`=1, `dout <= acc - 523689` (523689 = 769*681 = 2^19 - 599).
  - Else `dout <= acc[18:0]`.
  - Result is always < 2^19 and congruent to `a*b` mod 769.
  - Set `out_valid`=1 and go to HOLD.
- HOLD
  - `dout` and `out_valid` are held stable until `out_ready`=1.
  - On the transfer edge: `out_valid` <= 0, go to IDLE.
- Arithmetic:
  - All intermediates are unsigned.
  - `acc` is 20 bits. No overflow is possible, since 1023*1023 = 1046529 < 2^20.
- Simultaneous events:
  - `in_valid` is ignored outside IDLE.
  - There is no same-cycle accept-on-transfer. After a HOLD transfer, `in_ready` rises on the following cycle.
- Reset:
  - `rst` in any state aborts the operation, and the block is in IDLE on the next cycle.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `err_range`=0, `dout`=0.

## Timing
- Acceptance edge t0 moves the FSM to MUL.
- MUL occupies edges t1..t10.
- FOLD occupies edge t11.
- `out_valid` is visible after edge t11, i.e. 11 cycles after acceptance.
- With `out_ready` held high, the HOLD transfer occurs at t12 and `in_ready` is high after t12.
- Minimum issue interval is 13 cycles.
- `dout` changes only at FOLD and reset.
- `in_ready` and `out_valid` are registered and never both 1 in the same cycle.

## Configuration
- `MUL_FEED_769_RANGE_CHECK_EN` defined:
  - At capture, each operand ≥ 769 is replaced by `operand - 769` (always < 255).
  - `err_range` pulses 1 for the cycle after capture if either operand was ≥ 769.
- Not defined:
  - Operands are captured raw and `err_range` is tied 0.
  - Output congruence mod 769 still holds, because the fold covers all 10-bit inputs.

## Test plan
- a=5, b=7 -> `dout`=35, `out_valid` rises 11 cycles after acceptance, `in_ready` is low throughout.
- a=768, b=768 -> product 589824 folds to `dout`=66135; the reducer downstream yields 1.
- a=0, b=1023 and a=1023, b=1 -> `dout`=0, then `dout`=1023 without the macro or 254 with it.
- a=1023, b=1023 -> `dout`=522840 with the macro undefined; with the macro defined, `dout`=64516 and `err_range` pulses once. Both values are ≡ 689 mod 769.
- Back-pressure: `out_ready`=0 for 5 cycles after `out_valid` -> `dout` stable, `in_ready`=0, and a new `in_valid` is ignored. Transfer occurs on the first `out_ready`=1 edge, then IDLE.
- `rst` asserted at MUL cycle 4 -> next cycle `in_ready`=1, `out_valid`=0, `busy`=0. A fresh a=3, b=3 then gives `dout`=9 with no residue from the aborted operation.
